// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Contents: the FSM state encoding, the default operand and accumulator
// widths, and the iteration counter width with a helper that derives it.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_ACC_WIDTH = 2 * DEF_WIDTH;

    // One bit wider than needed to index WIDTH steps, so the count to
    // WIDTH-1 never needs special wrap handling.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned DEF_CNT_WIDTH = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mul_shift_add_dp.sv
// Arithmetic half of the sequential multiplier.
// It holds the multiplicand register, the 2W+1-bit partial product
// register P with its W+1-bit adder and shifter, and the accumulator adder,
// which keeps a sticky carry-out.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load           capture op_a into mcand and {0, op_b} into P
//   step           perform one add/shift iteration
//   finish         publish P as prod (and accumulate when acc_en)
//   acc_en         latched accumulate request for the current operation
//   clr_acc        clear acc and overflow (clear-then-load on finish)
//   op_a, op_b     operands
//   prod, acc      last product and accumulator
//   overflow       sticky accumulator carry-out
module mul_shift_add_dp
    import mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic                 acc_en,
    input  logic                 clr_acc,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [ACC_WIDTH-1:0] prod,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);

    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH:0]     p;
    logic [WIDTH:0]       sum;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] prod_new;

    // The top bit of P is always zero going into an add, so it is used as
    // the zero extension of the upper half for the W+1-bit sum.
    always_comb begin
        sum      = p[2*WIDTH:WIDTH] + {1'b0, (p[0] ? mcand : '0)};
        prod_new = p[ACC_WIDTH-1:0];
        acc_sum  = {1'b0, acc} + {1'b0, prod_new};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand    <= '0;
            p        <= '0;
            prod     <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                mcand <= op_a;
                p     <= {{(WIDTH + 1){1'b0}}, op_b};
            end else if (step) begin
                p <= {1'b0, sum, p[WIDTH-1:1]};
            end

            if (finish) begin
                prod <= prod_new;
            end

            // A clear coinciding with an accumulating finish clears first,
            // then loads the new product.
            if (finish && acc_en) begin
                if (clr_acc) begin
                    acc      <= prod_new;
                    overflow <= 1'b0;
                end else begin
                    acc      <= acc_sum[ACC_WIDTH-1:0];
                    overflow <= overflow | acc_sum[ACC_WIDTH];
                end
            end else if (clr_acc) begin
                acc      <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the iterative shift-add multiply/accumulate datapath.
// A start in IDLE captures the operands, runs WIDTH add/shift cycles in RUN,
// and spends one FIN cycle publishing the product and optionally
// accumulating it. The done pulse is visible in the cycle after FIN.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          request a multiply (sampled only in IDLE)
//   acc_mode       sampled with start; accumulate product at finish
//   clr_acc        clear acc and overflow, honoured in any state
//   op_a, op_b     unsigned operands, sampled with start
//   busy           high while not IDLE
//   done           one-cycle pulse when prod/acc have been updated
//   prod           last completed product
//   acc            accumulator
//   overflow       sticky accumulator carry-out
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 acc_mode,
    input  logic                 clr_acc,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] prod,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             acc_mode_q;
    logic             load;
    logic             step;
    logic             finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            acc_mode_q <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (load) begin
                cnt        <= '0;
                acc_mode_q <= acc_mode;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            done <= finish;
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    mul_shift_add_dp #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .acc_en   (acc_mode_q),
        .clr_acc  (clr_acc),
        .op_a     (op_a),
        .op_b     (op_b),
        .prod     (prod),
        .acc      (acc),
        .overflow (overflow)
    );

endmodule
